// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin two-master bus arbiter with turnaround and hold watchdog
//
// Purpose:
//   Arbitrates the serial system bus between master 1 and master 2 using a
//   round-robin policy. It owns the breq/bgrant handshake of both masters and
//   drives the bus master-select. One turnaround cycle separates tenures, and
//   a hold-time watchdog revokes a master that keeps the bus too long.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles of one grant tenure; 0 disables the watchdog
//   CNT_WIDTH       width of the hold counter; must be able to hold TIMEOUT_CYCLES
//
// Ports:
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   m1_breq      in   master 1 bus request, held high for the whole transaction
//   m2_breq      in   master 2 bus request, held high for the whole transaction
//   m1_bgrant    out  master 1 owns the bus
//   m2_bgrant    out  master 2 owns the bus
//   msel         out  bus mux select: 0 = master 1, 1 = master 2
//   bus_busy     out  high while any grant is high
//   timeout_err  out  one-cycle pulse when a tenure is revoked by the watchdog

module bus_arbiter_rr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic bus_busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    TURN   = 2'd3
  } state_e;

  // Encoding of last_grant: which master held the most recent tenure.
  localparam logic LAST_M1 = 1'b0;
  localparam logic LAST_M2 = 1'b1;

  localparam bit                   WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam int unsigned          FIRE_AT  = WD_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_WIDTH-1:0] FIRE_CNT = FIRE_AT[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 blocked1_q, blocked1_d;
  logic                 blocked2_q, blocked2_d;
  logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                 m1_bgrant_q, m1_bgrant_d;
  logic                 m2_bgrant_q, m2_bgrant_d;
  logic                 msel_q, msel_d;
  logic                 bus_busy_q, bus_busy_d;
  logic                 timeout_err_q, timeout_err_d;

  logic req1, req2;
  logic pick1, pick2;
  logic wd_fire;

  // A master revoked by the watchdog stays ineligible until it drops breq.
  assign req1 = m1_breq & ~blocked1_q;
  assign req2 = m2_breq & ~blocked2_q;

  // On contention the master that did not hold the last tenure wins.
  assign pick1 = req1 & (~req2 | (last_grant_q == LAST_M2));
  assign pick2 = req2 & ~pick1;

  // Fires on the edge that would start the (TIMEOUT_CYCLES+1)-th grant cycle.
  assign wd_fire = WD_EN && (hold_cnt_q == FIRE_CNT);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    blocked1_d    = blocked1_q;
    blocked2_d    = blocked2_q;
    hold_cnt_d    = hold_cnt_q;
    m1_bgrant_d   = m1_bgrant_q;
    m2_bgrant_d   = m2_bgrant_q;
    msel_d        = msel_q;
    bus_busy_d    = bus_busy_q;
    timeout_err_d = 1'b0;

    // A low breq always clears the block; setting a block below only happens
    // while that breq is high, so the two never collide.
    if (!m1_breq) blocked1_d = 1'b0;
    if (!m2_breq) blocked2_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick1) begin
          state_d      = GRANT1;
          m1_bgrant_d  = 1'b1;
          msel_d       = 1'b0;
          last_grant_d = LAST_M1;
          hold_cnt_d   = '0;
          bus_busy_d   = 1'b1;
        end else if (pick2) begin
          state_d      = GRANT2;
          m2_bgrant_d  = 1'b1;
          msel_d       = 1'b1;
          last_grant_d = LAST_M2;
          hold_cnt_d   = '0;
          bus_busy_d   = 1'b1;
        end
      end

      GRANT1: begin
        // A release on the fire edge wins over the watchdog: no error, no block.
        if (!m1_breq) begin
          state_d     = TURN;
          m1_bgrant_d = 1'b0;
          bus_busy_d  = 1'b0;
        end else if (wd_fire) begin
          state_d       = TURN;
          m1_bgrant_d   = 1'b0;
          bus_busy_d    = 1'b0;
          timeout_err_d = 1'b1;
          blocked1_d    = 1'b1;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end

      GRANT2: begin
        if (!m2_breq) begin
          state_d     = TURN;
          m2_bgrant_d = 1'b0;
          bus_busy_d  = 1'b0;
        end else if (wd_fire) begin
          state_d       = TURN;
          m2_bgrant_d   = 1'b0;
          bus_busy_d    = 1'b0;
          timeout_err_d = 1'b1;
          blocked2_d    = 1'b1;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end

      TURN: begin
        // Bus idle for one cycle; msel keeps pointing at the previous owner.
        state_d     = IDLE;
        m1_bgrant_d = 1'b0;
        m2_bgrant_d = 1'b0;
        bus_busy_d  = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        m1_bgrant_d = 1'b0;
        m2_bgrant_d = 1'b0;
        bus_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_grant_q  <= LAST_M2;
      blocked1_q    <= 1'b0;
      blocked2_q    <= 1'b0;
      hold_cnt_q    <= '0;
      m1_bgrant_q   <= 1'b0;
      m2_bgrant_q   <= 1'b0;
      msel_q        <= 1'b0;
      bus_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      blocked1_q    <= blocked1_d;
      blocked2_q    <= blocked2_d;
      hold_cnt_q    <= hold_cnt_d;
      m1_bgrant_q   <= m1_bgrant_d;
      m2_bgrant_q   <= m2_bgrant_d;
      msel_q        <= msel_d;
      bus_busy_q    <= bus_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign m1_bgrant   = m1_bgrant_q;
  assign m2_bgrant   = m2_bgrant_q;
  assign msel        = msel_q;
  assign bus_busy    = bus_busy_q;
  assign timeout_err = timeout_err_q;

  // Grants are one-hot or zero, and busy tracks them exactly.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
    !(m1_bgrant_q && m2_bgrant_q));
  a_busy_matches: assert property (@(posedge clk) disable iff (!rstn)
    bus_busy_q == (m1_bgrant_q | m2_bgrant_q));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr

module tb_bus_arbiter_rr;

  logic clk;
  logic rstn;
  logic m1_breq;
  logic m2_breq;
  logic m1_bgrant;
  logic m2_bgrant;
  logic msel;
  logic bus_busy;
  logic timeout_err;

  int checks;
  int errors;

  // Observed outputs packed as {m1_bgrant, m2_bgrant, msel, bus_busy, timeout_err}.
  logic [4:0] outs;
  assign outs = {m1_bgrant, m2_bgrant, msel, bus_busy, timeout_err};

  localparam logic [4:0] O_ZERO  = 5'b00000;
  localparam logic [4:0] O_G1    = 5'b10010;
  localparam logic [4:0] O_G2    = 5'b01110;
  localparam logic [4:0] O_IDLE2 = 5'b00100;
  localparam logic [4:0] O_TERR1 = 5'b00001;

  bus_arbiter_rr #(
    .TIMEOUT_CYCLES(8),
    .CNT_WIDTH     (11)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m1_breq    (m1_breq),
    .m2_breq    (m2_breq),
    .m1_bgrant  (m1_bgrant),
    .m2_bgrant  (m2_bgrant),
    .msel       (msel),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    m1_breq = 1'b0;
    m2_breq = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    m1_breq = 1'b1;
    m2_breq = 1'b1;
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL reset_hold_a: got %b want %b", outs, O_ZERO);
    end
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL reset_hold_b: got %b want %b", outs, O_ZERO);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (outs !== O_G1) begin
      errors++;
      $display("FAIL reset_first_grant_m1: got %b want %b", outs, O_G1);
    end
    m1_breq = 1'b0;
    m2_breq = 1'b0;
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL reset_release_turn: got %b want %b", outs, O_ZERO);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (outs !== O_ZERO) begin
        errors++;
        $display("FAIL single_idle_edge%0d: got %b want %b", e, outs, O_ZERO);
      end
    end
    m2_breq = 1'b1;
    for (int e = 5; e <= 11; e++) begin
      tick();
      checks++;
      if (outs !== O_G2) begin
        errors++;
        $display("FAIL single_grant_edge%0d: got %b want %b", e, outs, O_G2);
      end
    end
    m2_breq = 1'b0;
    for (int e = 12; e <= 14; e++) begin
      tick();
      checks++;
      if (outs !== O_IDLE2) begin
        errors++;
        $display("FAIL single_release_edge%0d: got %b want %b", e, outs, O_IDLE2);
      end
    end
  endtask

  task automatic test_contention();
    int exp_m;
    logic [4:0] exp_g;
    logic [4:0] exp_l;
    do_reset();
    m1_breq = 1'b1;
    m2_breq = 1'b1;
    exp_m = 1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (exp_m == 1) ? O_G1 : O_G2;
      exp_l = (exp_m == 1) ? O_ZERO : O_IDLE2;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (outs !== exp_g) begin
          errors++;
          $display("FAIL contention_tenure%0d_cyc%0d: got %b want %b", t, c, outs, exp_g);
        end
      end
      if (exp_m == 1) m1_breq = 1'b0;
      else            m2_breq = 1'b0;
      tick();
      checks++;
      if (outs !== exp_l) begin
        errors++;
        $display("FAIL contention_gap1_%0d: got %b want %b", t, outs, exp_l);
      end
      m1_breq = 1'b1;
      m2_breq = 1'b1;
      tick();
      checks++;
      if (outs !== exp_l) begin
        errors++;
        $display("FAIL contention_gap2_%0d: got %b want %b", t, outs, exp_l);
      end
      exp_m = (exp_m == 1) ? 2 : 1;
    end
    m1_breq = 1'b0;
    m2_breq = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    m1_breq = 1'b1;
    m2_breq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (outs !== O_G1) begin
        errors++;
        $display("FAIL wd_hold_cyc%0d: got %b want %b", c, outs, O_G1);
      end
    end
    tick();
    checks++;
    if (outs !== O_TERR1) begin
      errors++;
      $display("FAIL wd_revoke: got %b want %b", outs, O_TERR1);
    end
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL wd_turn_pulse_end: got %b want %b", outs, O_ZERO);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (outs !== O_G2) begin
        errors++;
        $display("FAIL wd_m2_grant_cyc%0d: got %b want %b", c, outs, O_G2);
      end
    end
    m2_breq = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (outs !== O_IDLE2) begin
        errors++;
        $display("FAIL wd_m1_blocked_cyc%0d: got %b want %b", c, outs, O_IDLE2);
      end
    end
    m1_breq = 1'b0;
    tick();
    checks++;
    if (outs !== O_IDLE2) begin
      errors++;
      $display("FAIL wd_m1_drop: got %b want %b", outs, O_IDLE2);
    end
    m1_breq = 1'b1;
    tick();
    checks++;
    if (outs !== O_G1) begin
      errors++;
      $display("FAIL wd_m1_regrant: got %b want %b", outs, O_G1);
    end
    m1_breq = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_same_edge();
    do_reset();
    m1_breq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (outs !== O_G1) begin
        errors++;
        $display("FAIL same_edge_hold_cyc%0d: got %b want %b", c, outs, O_G1);
      end
    end
    m1_breq = 1'b0;
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL same_edge_release: got %b want %b", outs, O_ZERO);
    end
    m1_breq = 1'b1;
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL same_edge_turn: got %b want %b", outs, O_ZERO);
    end
    tick();
    checks++;
    if (outs !== O_G1) begin
      errors++;
      $display("FAIL same_edge_not_blocked: got %b want %b", outs, O_G1);
    end
    m1_breq = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_midreset();
    do_reset();
    m2_breq = 1'b1;
    tick();
    checks++;
    if (outs !== O_G2) begin
      errors++;
      $display("FAIL midreset_grant: got %b want %b", outs, O_G2);
    end
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL midreset_async_drop: got %b want %b", outs, O_ZERO);
    end
    m2_breq = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (outs !== O_ZERO) begin
      errors++;
      $display("FAIL midreset_after_release: got %b want %b", outs, O_ZERO);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    m1_breq = 1'b0;
    m2_breq = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_watchdog();
    test_same_edge();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
